// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bus: cache result in, register-file write out,
// plus the EX forwarding lookup and status.
interface mem_wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
);
  logic                  inValid;
  logic                  inReady;
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  memToReg;
  logic                  regWrite;
  logic [REG_AW-1:0]     writeReg;
  logic                  flush;
  logic                  rfWriteEnable;
  logic [REG_AW-1:0]     rfWriteReg;
  logic [DATA_WIDTH-1:0] rfWriteData;
  logic                  rfReady;
  logic [REG_AW-1:0]     fwdQueryReg;
  logic                  fwdHit;
  logic [DATA_WIDTH-1:0] fwdData;
  logic                  poisonSeen;
  logic [15:0]           retiredCount;

  modport master (
    output inValid, readData, aluResult, memToReg,
    output regWrite, writeReg, flush, rfReady,
    output fwdQueryReg,
    input  inReady, rfWriteEnable, rfWriteReg,
    input  rfWriteData, fwdHit, fwdData,
    input  poisonSeen, retiredCount
  );

  modport slave (
    input  inValid, readData, aluResult, memToReg,
    input  regWrite, writeReg, flush, rfReady,
    input  fwdQueryReg,
    output inReady, rfWriteEnable, rfWriteReg,
    output rfWriteData, fwdHit, fwdData,
    output poisonSeen, retiredCount
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Write-back stage: skid FIFO of MEM results retiring to the
// register file, with youngest-first forwarding lookup.
module mem_wb_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_AW     = 5,
  parameter int                    DEPTH      = 2,
  parameter int                    ZERO_REG   = 31,
  parameter logic [DATA_WIDTH-1:0] POISON     = 32'hDEADBEEF
) (
  input logic           clock,
  input logic           reset,
  mem_wb_stage_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [REG_AW-1:0] ZREG = REG_AW'(ZERO_REG);

  typedef struct packed {
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        slots [DEPTH];
  entry_t        inEntry;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [15:0]   retired;
  logic          poison;
  logic          notEmpty;
  logic          accept;
  logic          keep;
  logic          pop;
  logic          poisonIn;

  assign notEmpty = (count != '0);
  assign accept   = bus.inValid && (count != FULL);
  assign keep     = accept && bus.regWrite
                    && (bus.writeReg != ZREG);
  assign pop      = notEmpty && bus.rfReady;
  assign poisonIn = accept && bus.memToReg
                    && (bus.readData == POISON);

  assign inEntry.rd   = bus.writeReg;
  assign inEntry.data = bus.memToReg ? bus.readData
                                     : bus.aluResult;

  assign bus.inReady       = (count != FULL);
  assign bus.rfWriteEnable = notEmpty;
  assign bus.rfWriteReg    = notEmpty ? slots[head].rd : '0;
  assign bus.rfWriteData   = notEmpty ? slots[head].data : '0;
  assign bus.retiredCount  = retired;
  assign bus.poisonSeen    = poison;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      retired <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (keep) tail <= tail + 1'b1;
      if (pop) begin
        head    <= head + 1'b1;
        retired <= retired + 16'd1;
      end
      count <= count + CW'(keep) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (keep && !bus.flush) slots[tail] <= inEntry;
  end

  // A flushed input is discarded entirely, poison included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) poison <= 1'b0;
    else if (poisonIn && !bus.flush) poison <= 1'b1;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    bus.fwdHit  = 1'b0;
    bus.fwdData = '0;
    if (bus.fwdQueryReg != ZREG) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count)
            && (slots[idx].rd == bus.fwdQueryReg)) begin
          bus.fwdHit  = 1'b1;
          bus.fwdData = slots[idx].data;
        end
      end
    end
  end
endmodule
